uart: RTL and testbench
=======================

# uart

Full-duplex 8N1 UART with AXI-Stream byte interfaces for the memory-mapped UART wrapper. The transmitter serialises bytes accepted on the input stream onto `txd`. The receiver deserialises `rxd` into bytes presented on the output stream. Bit rate is set at run time by `prescale`: one bit lasts `prescale*8` clock cycles, so the wrapper drives clk/(baud*8).

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, both directions.
- `clk`, input, 1: clock, all logic on rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `input_axis_tdata`, input, DATA_WIDTH: byte to transmit.
- `input_axis_tvalid`, input, 1: transmit byte valid.
- `input_axis_tready`, output, 1: transmitter idle and able to accept a byte.
- `output_axis_tdata`, output, DATA_WIDTH: last received byte.
- `output_axis_tvalid`, output, 1: received byte pending.
- `output_axis_tready`, input, 1: consumer takes the pending byte.
- `rxd`, input, 1: serial in, idle high.
- `txd`, output, 1: serial out, idle high.
- `tx_busy`, output, 1: a transmit frame is in progress.
- `rx_busy`, output, 1: a receive frame is in progress.
- `rx_overrun_error`, output, 1: one-cycle pulse.
- `rx_frame_error`, output, 1: one-cycle pulse.
- `prescale`, input, 16: clock cycles per 1/8 bit. Legal values ≥1. Latched at frame start, whether transmit accept or receive start detect.

## Operation
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1). No parity.
- TX accept: the transmitter accepts a byte in a cycle where `input_axis_tvalid & input_axis_tready`.
  - The byte and `prescale` are latched.
  - `input_axis_tready` deasserts and `tx_busy` asserts.
- TX shifting: `txd` drives the start bit, then the data bits, then the stop bit, each for exactly `prescale*8` cycles.
- TX completion: after the stop bit period, `tx_busy` clears and `input_axis_tready` reasserts. `txd` stays high.
- RX input register: `rxd` passes through a 2-flop synchroniser before use.
- RX start detect: in idle, a low synchronised `rxd` starts a half-bit wait of `prescale*4` cycles.
  - If the line is still low at the end of the wait, the start is confirmed and `rx_busy` asserts.
  - Otherwise this is a false start: return to idle, no output.
- RX sampling: data bits are sampled every `prescale*8` cycles after the start-bit midpoint, then the stop bit is sampled one further period later.
- RX stop = 1:
  - `output_axis_tdata` is loaded and `output_axis_tvalid` is set.
  - If `output_axis_tvalid` was already set and not consumed in that same cycle, the new byte overwrites the old one and `rx_overrun_error` pulses for one cycle.
- RX stop = 0: `rx_frame_error` pulses for one cycle, the byte is discarded, and `output_axis_tvalid` is unchanged.
- After the stop sample: `rx_busy` clears, and the receiver returns to idle and immediately looks for the next start bit.
- `output_axis_tvalid` clears on `output_axis_tvalid & output_axis_tready`. If a new byte completes in that same cycle, the new byte wins: valid stays 1, with no overrun.
- TX and RX are fully independent and may run simultaneously.

## Timing
- Reset (rst=0) values:
  - `txd`=1, `input_axis_tready`=0, `tx_busy`=0.
  - `output_axis_tvalid`=0, `output_axis_tdata`=0, `rx_busy`=0, both error outputs 0.
  - Counters and shift registers cleared.
- After reset release: `input_axis_tready`=1 on the first clock edge.
- Reset mid-frame aborts both directions at once. `txd` returns high in the same edge.
- TX latency: the start bit appears on `txd` in the cycle after the accept edge.
- TX frame length: (DATA_WIDTH+2)*prescale*8 cycles from accept to `input_axis_tready` reasserting. With prescale=1, that is 80 cycles.
- RX latency: `output_axis_tvalid` rises 2 cycles (synchroniser) + prescale*4 + (DATA_WIDTH+1)*prescale*8 cycles after the falling start edge on `rxd`, ±1 cycle.
- `input_axis_tvalid` asserted while `input_axis_tready`=0 is ignored. The data is not captured.
- A changed `prescale` takes effect at the next frame only.

## Test plan
- Reset: hold rst=0 with random inputs -> `txd`=1, `input_axis_tready`=0, `output_axis_tvalid`=0. Release -> `input_axis_tready`=1 after one edge.
- TX 0xA5, prescale=1 -> `txd` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 8 cycles. `input_axis_tready` returns high 80 cycles after accept.
- Loopback `txd`→`rxd`, prescale=2, send 0x3C -> `output_axis_tvalid`=1 with data 0x3C. Both error outputs stay 0.
- Send 0x11 then 0x22 with `output_axis_tready`=0 -> `rx_overrun_error` pulses once and `output_axis_tdata`=0x22.
- Drive a frame with stop bit 0 -> `rx_frame_error` pulses once and `output_axis_tvalid` stays 0.
- 2-cycle low glitch on `rxd` with prescale=4 -> no `rx_busy` after the half-bit check, and no valid or error output.

Source files
------------

// File: rtl/uart.sv
// Full-duplex 8N1 UART with AXI-Stream byte interfaces.
// One bit lasts prescale*8 clock cycles; prescale is captured at the start of
// every transmit or receive frame, so a new value only affects later frames.
module uart #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  input  logic                  rxd,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error,
  input  logic [15:0]           prescale
);

  localparam int BITS_W = $clog2(DATA_WIDTH + 2);
  // Bits still to go after the start bit: data bits plus the stop bit.
  localparam logic [BITS_W-1:0] FRAME_BITS = BITS_W'(DATA_WIDTH + 1);
  localparam logic [BITS_W-1:0] ONE_BIT    = BITS_W'(1);
  localparam logic [BITS_W-1:0] NO_BITS    = BITS_W'(0);

  typedef enum logic [0:0] {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

  // Transmit state
  tx_state_t             tx_state_r;
  logic                  tx_ready_r;
  logic                  tx_busy_r;
  logic                  txd_r;
  logic [DATA_WIDTH:0]   tx_shift_r;
  logic [18:0]           tx_cnt_r;
  logic [BITS_W-1:0]     tx_bits_r;
  logic [15:0]           tx_prescale_r;

  // Receive state
  rx_state_t             rx_state_r;
  logic                  rxd_meta_r;
  logic                  rxd_sync_r;
  logic                  rx_busy_r;
  logic [DATA_WIDTH-1:0] rx_shift_r;
  logic [18:0]           rx_cnt_r;
  logic [BITS_W-1:0]     rx_bits_r;
  logic [15:0]           rx_prescale_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic                  rx_overrun_r;
  logic                  rx_frame_r;

  // Reload values for the down counters (count N-1 .. 0 gives N cycles)
  logic [18:0] bit_period_s;
  logic [18:0] half_period_s;
  logic [18:0] tx_period_s;
  logic [18:0] rx_period_s;

  assign bit_period_s  = {prescale, 3'b000} - 19'd1;
  assign half_period_s = {1'b0, prescale, 2'b00} - 19'd1;
  assign tx_period_s   = {tx_prescale_r, 3'b000} - 19'd1;
  assign rx_period_s   = {rx_prescale_r, 3'b000} - 19'd1;

  assign input_axis_tready  = tx_ready_r;
  assign tx_busy            = tx_busy_r;
  assign txd                = txd_r;
  assign rx_busy            = rx_busy_r;
  assign output_axis_tdata  = out_data_r;
  assign output_axis_tvalid = out_valid_r;
  assign rx_overrun_error   = rx_overrun_r;
  assign rx_frame_error     = rx_frame_r;

  // Transmit FSM: accept a byte, then drive start, data (LSB first) and stop bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_r    <= TX_IDLE;
      tx_ready_r    <= 1'b0;
      tx_busy_r     <= 1'b0;
      txd_r         <= 1'b1;
      tx_shift_r    <= {(DATA_WIDTH+1){1'b0}};
      tx_cnt_r      <= 19'd0;
      tx_bits_r     <= NO_BITS;
      tx_prescale_r <= 16'd0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          txd_r <= 1'b1;
          if (input_axis_tvalid && tx_ready_r) begin
            tx_shift_r    <= {1'b1, input_axis_tdata};
            tx_prescale_r <= prescale;
            tx_cnt_r      <= bit_period_s;
            tx_bits_r     <= FRAME_BITS;
            txd_r         <= 1'b0;
            tx_ready_r    <= 1'b0;
            tx_busy_r     <= 1'b1;
            tx_state_r    <= TX_SHIFT;
          end else begin
            tx_ready_r <= 1'b1;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt_r == 19'd0) begin
            if (tx_bits_r == NO_BITS) begin
              // Stop bit period over: line is already high, open for the next byte
              tx_ready_r <= 1'b1;
              tx_busy_r  <= 1'b0;
              txd_r      <= 1'b1;
              tx_state_r <= TX_IDLE;
            end else begin
              txd_r      <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[DATA_WIDTH:1]};
              tx_bits_r  <= tx_bits_r - ONE_BIT;
              tx_cnt_r   <= tx_period_s;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r - 19'd1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx_ready_r <= 1'b0;
          tx_busy_r  <= 1'b0;
          txd_r      <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchroniser bringing the asynchronous rxd into the clock domain
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  // Receive FSM: validate start at mid-bit, sample data and stop, manage output stream
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_r    <= RX_IDLE;
      rx_busy_r     <= 1'b0;
      rx_shift_r    <= {DATA_WIDTH{1'b0}};
      rx_cnt_r      <= 19'd0;
      rx_bits_r     <= NO_BITS;
      rx_prescale_r <= 16'd0;
      out_data_r    <= {DATA_WIDTH{1'b0}};
      out_valid_r   <= 1'b0;
      rx_overrun_r  <= 1'b0;
      rx_frame_r    <= 1'b0;
    end else begin
      rx_overrun_r <= 1'b0;
      rx_frame_r   <= 1'b0;
      // A consumed byte drops valid; a byte completing in this cycle overrides below
      if (out_valid_r && output_axis_tready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      case (rx_state_r)
        RX_IDLE: begin
          if (!rxd_sync_r) begin
            rx_prescale_r <= prescale;
            rx_cnt_r      <= half_period_s;
            rx_state_r    <= RX_START;
          end else begin
            rx_cnt_r <= 19'd0;
          end
        end
        RX_START: begin
          if (rx_cnt_r == 19'd0) begin
            if (!rxd_sync_r) begin
              rx_busy_r  <= 1'b1;
              rx_cnt_r   <= rx_period_s;
              rx_bits_r  <= FRAME_BITS;
              rx_state_r <= RX_DATA;
            end else begin
              // Line went back high before mid-bit: treat as a glitch
              rx_state_r <= RX_IDLE;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - 19'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == 19'd0) begin
            if (rx_bits_r == ONE_BIT) begin
              if (rxd_sync_r) begin
                out_data_r   <= rx_shift_r;
                out_valid_r  <= 1'b1;
                rx_overrun_r <= out_valid_r && !output_axis_tready;
              end else begin
                rx_frame_r <= 1'b1;
              end
              rx_busy_r  <= 1'b0;
              rx_state_r <= RX_IDLE;
            end else begin
              rx_shift_r <= {rxd_sync_r, rx_shift_r[DATA_WIDTH-1:1]};
              rx_bits_r  <= rx_bits_r - ONE_BIT;
              rx_cnt_r   <= rx_period_s;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - 19'd1;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          rx_busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: directed scenarios plus randomized frames,
// checked against a frame-level reference model of the serial line and the
// receive stream held in plain variables.
module tb_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  input_axis_tdata;
  logic        input_axis_tvalid;
  logic        input_axis_tready;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready;
  logic        rxd;
  logic        txd;
  logic        tx_busy;
  logic        rx_busy;
  logic        rx_overrun_error;
  logic        rx_frame_error;
  logic [15:0] prescale;

  logic rxd_drv;
  logic loop_en;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart #(.DATA_WIDTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .rxd                (rxd),
    .txd                (txd),
    .tx_busy            (tx_busy),
    .rx_busy            (rx_busy),
    .rx_overrun_error   (rx_overrun_error),
    .rx_frame_error     (rx_frame_error),
    .prescale           (prescale)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model of the receive stream
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  int         exp_overrun = 0;
  int         exp_frame   = 0;

  // Pulse / activity counters observed on the DUT outputs
  int overrun_seen = 0;
  int frame_seen   = 0;
  int rxbusy_seen  = 0;

  // Count error pulses and busy cycles once per clock, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (rx_overrun_error) overrun_seen++;
      if (rx_frame_error)   frame_seen++;
      if (rx_busy)          rxbusy_seen++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one byte through the transmitter and check the txd waveform bit by bit
  task automatic tx_frame(input logic [7:0] b, input int p, input string tag);
    logic [9:0] bits;
    int period;
    int waited;
    bits   = {1'b1, b, 1'b0};
    period = 8 * p;
    prescale = 16'(p);
    waited = 0;
    @(negedge clk);
    while (!input_axis_tready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check_eq($sformatf("%s_ready_wait", tag), 32'(input_axis_tready), 32'd1);
    input_axis_tdata  = b;
    input_axis_tvalid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10 * period; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Keep valid high with other data: must be ignored while busy
        input_axis_tdata = ~b;
        check_eq($sformatf("%s_busy", tag), 32'(tx_busy), 32'd1);
      end
      if ((k % period == 0) || (k % period == period - 1))
        check_eq($sformatf("%s_txd_k%0d", tag, k), 32'(txd), 32'(bits[k / period]));
      if (k == 10 * period - 1) begin
        check_eq($sformatf("%s_ready_low_end", tag), 32'(input_axis_tready), 32'd0);
        input_axis_tvalid = 1'b0;
      end
    end
    @(negedge clk);
    check_eq($sformatf("%s_ready_back", tag), 32'(input_axis_tready), 32'd1);
    check_eq($sformatf("%s_busy_clear", tag), 32'(tx_busy), 32'd0);
    @(negedge clk);
    check_eq($sformatf("%s_txd_idle", tag), 32'(txd), 32'd1);
  endtask

  // Drive one serial frame onto rxd, update the model, then compare the stream
  task automatic rx_frame(input logic [7:0] b, input int p, input logic stop, input string tag);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    prescale = 16'(p);
    for (int i = 0; i < 10; i++) begin
      rxd_drv = bits[i];
      repeat (8 * p) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (8 * p + 4) @(negedge clk);
    if (stop) begin
      if (exp_valid) exp_overrun++;
      exp_valid = 1'b1;
      exp_data  = b;
    end else begin
      exp_frame++;
    end
    check_eq($sformatf("%s_valid", tag),   32'(output_axis_tvalid), 32'(exp_valid));
    check_eq($sformatf("%s_data", tag),    32'(output_axis_tdata),  32'(exp_data));
    check_eq($sformatf("%s_overrun", tag), 32'(overrun_seen),       32'(exp_overrun));
    check_eq($sformatf("%s_ferr", tag),    32'(frame_seen),         32'(exp_frame));
    check_eq($sformatf("%s_rxbusy", tag),  32'(rx_busy),            32'd0);
  endtask

  // Take the pending byte (if any) with a one-cycle ready pulse
  task automatic consume(input string tag);
    output_axis_tready = 1'b1;
    @(negedge clk);
    output_axis_tready = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
    check_eq($sformatf("%s_consumed", tag), 32'(output_axis_tvalid), 32'(exp_valid));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_busy;
    int p;
    logic [7:0] b;
    logic stop;

    rst = 1'b0;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    input_axis_tdata = 8'h00;
    input_axis_tvalid = 1'b0;
    output_axis_tready = 1'b0;
    prescale = 16'd1;

    // Reset with random inputs toggling
    repeat (6) begin
      @(negedge clk);
      input_axis_tdata   = 8'($urandom);
      input_axis_tvalid  = 1'($urandom);
      output_axis_tready = 1'($urandom);
      rxd_drv            = 1'($urandom);
      prescale           = 16'($urandom_range(1, 9));
    end
    @(negedge clk);
    check_eq("rst_txd",    32'(txd),                32'd1);
    check_eq("rst_tready", 32'(input_axis_tready),  32'd0);
    check_eq("rst_txbusy", 32'(tx_busy),            32'd0);
    check_eq("rst_valid",  32'(output_axis_tvalid), 32'd0);
    check_eq("rst_tdata",  32'(output_axis_tdata),  32'd0);
    check_eq("rst_rxbusy", 32'(rx_busy),            32'd0);
    input_axis_tvalid = 1'b0;
    output_axis_tready = 1'b0;
    rxd_drv = 1'b1;
    prescale = 16'd1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel_tready", 32'(input_axis_tready), 32'd1);

    // Directed transmit: 0xA5 at prescale 1 (80-cycle frame)
    tx_frame(8'hA5, 1, "tx_a5");

    // Loopback at prescale 2
    loop_en = 1'b1;
    tx_frame(8'h3C, 2, "loop");
    repeat (20) @(negedge clk);
    exp_valid = 1'b1;
    exp_data  = 8'h3C;
    check_eq("loop_valid",   32'(output_axis_tvalid), 32'(exp_valid));
    check_eq("loop_data",    32'(output_axis_tdata),  32'(exp_data));
    check_eq("loop_overrun", 32'(overrun_seen),       32'(exp_overrun));
    check_eq("loop_ferr",    32'(frame_seen),         32'(exp_frame));
    loop_en = 1'b0;
    consume("loop");

    // Overrun: two bytes with nobody consuming
    rx_frame(8'h11, 1, 1'b1, "ovr1");
    rx_frame(8'h22, 1, 1'b1, "ovr2");
    consume("ovr");

    // Frame error: stop bit low, byte dropped
    rx_frame(8'h5A, 2, 1'b0, "ferr");

    // Short glitch at prescale 4 must be rejected
    snap_busy = rxbusy_seen;
    prescale = 16'd4;
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_busy",    32'(rxbusy_seen),        32'(snap_busy));
    check_eq("glitch_valid",   32'(output_axis_tvalid), 32'(exp_valid));
    check_eq("glitch_overrun", 32'(overrun_seen),       32'(exp_overrun));
    check_eq("glitch_ferr",    32'(frame_seen),         32'(exp_frame));

    // Randomized transmit frames
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      p = int'($urandom_range(1, 3));
      tx_frame(b, p, $sformatf("rtx%0d", i));
    end

    // Randomized receive frames with random consumption and stop bits
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) consume($sformatf("rc%0d", i));
      b = 8'($urandom);
      p = int'($urandom_range(1, 3));
      stop = ($urandom_range(0, 3) != 0);
      rx_frame(b, p, stop, $sformatf("rrx%0d", i));
    end

    // Reset in the middle of a transmit and a receive frame
    prescale = 16'd1;
    @(negedge clk);
    input_axis_tdata  = 8'h00;
    input_axis_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_axis_tvalid = 1'b0;
    rxd_drv = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("mid_txd",    32'(txd),     32'd0);
    check_eq("mid_rxbusy", 32'(rx_busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_txd",    32'(txd),                32'd1);
    check_eq("abort_txbusy", 32'(tx_busy),            32'd0);
    check_eq("abort_rxbusy", 32'(rx_busy),            32'd0);
    check_eq("abort_tready", 32'(input_axis_tready),  32'd0);
    check_eq("abort_valid",  32'(output_axis_tvalid), 32'd0);
    rxd_drv = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_rel_tready", 32'(input_axis_tready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
